net_tx_pkt_arbiter: RTL and testbench
=====================================

# net_tx_pkt_arbiter

Packet-granular round-robin arbiter that merges two 512-bit AXI-Stream transmit sources onto the single network TX port. Source 0 is the TCP offload engine's TX stream; source 1 is the endpoint bypass path. Once a packet is granted it is never interleaved, so each frame leaves intact on `m_axis_net_tx`. The `dest` sideband tags each beat with its source index, and per-source packet counters are exported for status.

## Interface
- `DATA_WIDTH`, 512, tdata width for all streams
- `KEEP_WIDTH`, DATA_WIDTH/8, tkeep width
- `CNT_WIDTH`, 32, width of each packet counter
- `net_clk` in 1 — single clock for all logic
- `net_aresetn` in 1 — synchronous, active-low reset
- `s_axis_in0_data` in DATA_WIDTH — source 0 (TCP engine) beat data
- `s_axis_in0_keep` in KEEP_WIDTH — source 0 byte enables
- `s_axis_in0_last` in 1 — source 0 end of packet
- `s_axis_in0_valid` in 1 — source 0 beat valid
- `s_axis_in0_ready` out 1 — source 0 beat accepted
- `s_axis_in1_data` / `s_axis_in1_keep` / `s_axis_in1_last` / `s_axis_in1_valid` in, `s_axis_in1_ready` out — source 1 (endpoint bypass), same widths as source 0
- `m_axis_net_tx_data` out DATA_WIDTH — merged beat data
- `m_axis_net_tx_keep` out KEEP_WIDTH — merged byte enables
- `m_axis_net_tx_last` out 1 — merged end of packet
- `m_axis_net_tx_dest` out 1 — source index of the current beat
- `m_axis_net_tx_valid` out 1 — output beat valid
- `m_axis_net_tx_ready` in 1 — downstream accepts beat
- `pkt_cnt0` out CNT_WIDTH — packets fully accepted from source 0
- `pkt_cnt1` out CNT_WIDTH — packets fully accepted from source 1
- `busy` out 1 — high while in GRANT state

## Operation
- FSM states: IDLE and GRANT. Registers: `grant_idx` (1 bit) and `last_grant` (1 bit).
- IDLE:
  - Both `s_axis_inX_ready` = 0.
  - If exactly one `valid` is high, grant that source.
  - If both are high, grant `!last_grant`.
  - On a grant, register `grant_idx` and `last_grant` <= granted index, then go to GRANT.
  - If neither is high, stay in IDLE.
- GRANT:
  - `s_axis_in[grant_idx]_ready` = `out_free`. The other source's ready = 0.
  - `out_free` = !`m_axis_net_tx_valid` || `m_axis_net_tx_ready`.
  - Each accepted beat (valid && ready) loads the output register with data, keep, last, and `dest` = `grant_idx`.
  - When the accepted beat has `last` = 1: increment `pkt_cnt[grant_idx]` and return to IDLE.
- Output register:
  - `m_axis_net_tx_valid` sets on an accepted beat.
  - It clears on `m_axis_net_tx_ready` when no new beat is accepted in the same cycle.
  - Simultaneous drain and load is allowed, giving full throughput within a packet.
- Counters are unsigned and wrap from 2^CNT_WIDTH−1 to 0. There is no saturation.
- Inputs that are not granted are only stalled, never dropped. A source holding valid will be granted within one foreign packet.
- No length limit is enforced. A source that never asserts `last` holds the grant indefinitely; this is by design, and upstream guarantees framing.
- `keep` is passed through unmodified. `keep` = 0 beats are forwarded as-is.

## Timing
- Reset (`net_aresetn` = 0 at a `net_clk` edge) takes effect the following cycle:
  - state = IDLE, `grant_idx` = 0, `last_grant` = 1 (source 0 wins the first tie)
  - `m_axis_net_tx_valid` = 0; data, keep, last and dest = 0
  - both readies = 0, `busy` = 0, `pkt_cnt0` = `pkt_cnt1` = 0
- Reset mid-packet discards the partial packet and the output register contents. Downstream sees a truncated frame without `last`; the MAC/TCP side is reset together with this block.
- Latency: a source valid at cycle 0 in IDLE gives GRANT at cycle 1 (ready high), first beat accepted at cycle 1, and `m_axis_net_tx_valid` at cycle 2.
- Pipeline latency is 1 cycle per beat thereafter.
- Exactly one idle input cycle (the IDLE arbitration cycle) separates consecutive packets. Output bubble is ≥1 cycle per packet.
- A single-beat packet occupies GRANT for one cycle.
- `m_axis_net_tx_ready` low: output data, keep, last, dest and valid are held stable, and the granted source's ready = 0 in the same cycle (combinational through `out_free`).
- `valid` may assert in the same cycle as the FSM returns to IDLE; it is considered in that IDLE cycle.

## Test plan
- Single source: source 0 sends a 3-beat packet (data 0xA1, 0xA2, 0xA3; last on the 3rd), `m_axis_net_tx_ready` = 1 → output beats at cycles 2, 3, 4; dest = 0, last only on 0xA3; `pkt_cnt0` = 1.
- Tie after reset: both sources present 2-beat packets at the same cycle → source 0 packet out first, then source 1 after a 1-cycle gap; dest sequence 0,0,1,1; then `pkt_cnt0` = `pkt_cnt1` = 1.
- Fairness: source 0 streams 4 back-to-back 1-beat packets while source 1 holds one 1-beat packet valid → output dest order 0,1,0,0,0.
- Backpressure: 4-beat packet from source 1, with `m_axis_net_tx_ready` low for 3 cycles after the 2nd output beat → output stays on beat 2 with stable data, `s_axis_in1_ready` = 0 during the stall, all 4 beats delivered in order with no loss or duplication.
- Reset mid-packet: assert `net_aresetn` = 0 after beat 2 of a 5-beat source-0 packet → next cycle valid = 0, `busy` = 0, counters = 0. A fresh 1-beat packet from source 1 then exits with dest = 1.
- Counter wrap: build with CNT_WIDTH = 4 and send 17 packets on source 1 → `pkt_cnt1` reads 1 and `pkt_cnt0` remains 0.

Source files
------------

// File: rtl/net_tx_pkt_arbiter.sv
// Packet-granular round-robin merge of two AXI-Stream TX sources onto one network TX port.
// Latency: 1 IDLE arbitration cycle per packet, then 1 cycle per beat through the output register.
// Backpressure: granted source ready = !out_valid || out_ready (combinational); the other source is stalled.
//
// Ports:
//   net_clk / net_aresetn           clock, synchronous active-low reset
//   s_axis_in0_*                    source 0 (TCP offload engine) stream: data/keep/last/valid in, ready out
//   s_axis_in1_*                    source 1 (endpoint bypass) stream, same shape
//   m_axis_net_tx_*                 merged stream; dest carries the source index of each beat
//   pkt_cnt0 / pkt_cnt1             wrapping counts of packets fully accepted per source
//   busy                            high while a packet grant is held
module net_tx_pkt_arbiter #(
    parameter int DATA_WIDTH = 512,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  net_clk,
    input  logic                  net_aresetn,

    input  logic [DATA_WIDTH-1:0] s_axis_in0_data,
    input  logic [KEEP_WIDTH-1:0] s_axis_in0_keep,
    input  logic                  s_axis_in0_last,
    input  logic                  s_axis_in0_valid,
    output logic                  s_axis_in0_ready,

    input  logic [DATA_WIDTH-1:0] s_axis_in1_data,
    input  logic [KEEP_WIDTH-1:0] s_axis_in1_keep,
    input  logic                  s_axis_in1_last,
    input  logic                  s_axis_in1_valid,
    output logic                  s_axis_in1_ready,

    output logic [DATA_WIDTH-1:0] m_axis_net_tx_data,
    output logic [KEEP_WIDTH-1:0] m_axis_net_tx_keep,
    output logic                  m_axis_net_tx_last,
    output logic                  m_axis_net_tx_dest,
    output logic                  m_axis_net_tx_valid,
    input  logic                  m_axis_net_tx_ready,

    output logic [CNT_WIDTH-1:0]  pkt_cnt0,
    output logic [CNT_WIDTH-1:0]  pkt_cnt1,
    output logic                  busy
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic                  grant_idx_q, grant_idx_d;
    logic                  last_grant_q, last_grant_d;

    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic [KEEP_WIDTH-1:0] out_keep_q, out_keep_d;
    logic                  out_last_q, out_last_d;
    logic                  out_dest_q, out_dest_d;
    logic                  out_vld_q,  out_vld_d;

    logic [CNT_WIDTH-1:0]  cnt0_q, cnt0_d;
    logic [CNT_WIDTH-1:0]  cnt1_q, cnt1_d;

    logic                  out_free;
    logic                  accept;
    logic                  sel_valid;
    logic                  sel_last;
    logic [DATA_WIDTH-1:0] sel_data;
    logic [KEEP_WIDTH-1:0] sel_keep;
    logic                  pick;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    // Output register can take a beat when empty or draining this cycle.
    assign out_free  = !out_vld_q || m_axis_net_tx_ready;

    assign sel_valid = grant_idx_q ? s_axis_in1_valid : s_axis_in0_valid;
    assign sel_last  = grant_idx_q ? s_axis_in1_last  : s_axis_in0_last;
    assign sel_data  = grant_idx_q ? s_axis_in1_data  : s_axis_in0_data;
    assign sel_keep  = grant_idx_q ? s_axis_in1_keep  : s_axis_in0_keep;

    assign accept    = (state_q == ST_GRANT) && sel_valid && out_free;

    // Both requesting: alternate away from the previous winner; otherwise take the lone requester.
    assign pick      = (s_axis_in0_valid && s_axis_in1_valid) ? !last_grant_q : s_axis_in1_valid;

    assign s_axis_in0_ready = (state_q == ST_GRANT) && !grant_idx_q && out_free;
    assign s_axis_in1_ready = (state_q == ST_GRANT) &&  grant_idx_q && out_free;

    always_comb begin
        state_d      = state_q;
        grant_idx_d  = grant_idx_q;
        last_grant_d = last_grant_q;
        out_data_d   = out_data_q;
        out_keep_d   = out_keep_q;
        out_last_d   = out_last_q;
        out_dest_d   = out_dest_q;
        out_vld_d    = out_vld_q && !m_axis_net_tx_ready;
        cnt0_d       = cnt0_q;
        cnt1_d       = cnt1_q;

        case (state_q)
            ST_IDLE: begin
                if (s_axis_in0_valid || s_axis_in1_valid) begin
                    state_d      = ST_GRANT;
                    grant_idx_d  = pick;
                    last_grant_d = pick;
                end
            end
            ST_GRANT: begin
                if (accept) begin
                    out_data_d = sel_data;
                    out_keep_d = sel_keep;
                    out_last_d = sel_last;
                    out_dest_d = grant_idx_q;
                    out_vld_d  = 1'b1;
                    if (sel_last) begin
                        state_d = ST_IDLE;
                        if (grant_idx_q) begin
                            cnt1_d = cnt1_q + CNT_ONE;
                        end else begin
                            cnt0_d = cnt0_q + CNT_ONE;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge net_clk) begin
        if (!net_aresetn) begin
            state_q      <= ST_IDLE;
            grant_idx_q  <= 1'b0;
            last_grant_q <= 1'b1;   // makes source 0 win the first tie
            out_data_q   <= '0;
            out_keep_q   <= '0;
            out_last_q   <= 1'b0;
            out_dest_q   <= 1'b0;
            out_vld_q    <= 1'b0;
            cnt0_q       <= '0;
            cnt1_q       <= '0;
        end else begin
            state_q      <= state_d;
            grant_idx_q  <= grant_idx_d;
            last_grant_q <= last_grant_d;
            out_data_q   <= out_data_d;
            out_keep_q   <= out_keep_d;
            out_last_q   <= out_last_d;
            out_dest_q   <= out_dest_d;
            out_vld_q    <= out_vld_d;
            cnt0_q       <= cnt0_d;
            cnt1_q       <= cnt1_d;
        end
    end

    assign m_axis_net_tx_data  = out_data_q;
    assign m_axis_net_tx_keep  = out_keep_q;
    assign m_axis_net_tx_last  = out_last_q;
    assign m_axis_net_tx_dest  = out_dest_q;
    assign m_axis_net_tx_valid = out_vld_q;
    assign pkt_cnt0            = cnt0_q;
    assign pkt_cnt1            = cnt1_q;
    assign busy                = (state_q == ST_GRANT);

endmodule

// File: tb/tb_net_tx_pkt_arbiter.sv
// Bench for net_tx_pkt_arbiter: directed latency/backpressure/reset scenarios plus randomized
// packet traffic checked against a packet-level round-robin model.
// Counters are built 4 bits wide so the wrap case is reachable.
module tb_net_tx_pkt_arbiter;

    localparam int DW = 512;
    localparam int KW = DW / 8;
    localparam int CW = 4;

    typedef struct {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic          last;
        logic          dest;
        int            cyc;
    } beat_t;

    logic          clk = 1'b0;
    logic          arstn = 1'b0;
    logic [DW-1:0] d0 = '0, d1 = '0;
    logic [KW-1:0] k0 = '0, k1 = '0;
    logic          l0 = 1'b0, l1 = 1'b0, v0 = 1'b0, v1 = 1'b0;
    logic          rdy0, rdy1;
    logic [DW-1:0] o_data;
    logic [KW-1:0] o_keep;
    logic          o_last, o_dest, o_valid;
    logic          m_ready = 1'b1;
    logic [CW-1:0] cnt0, cnt1;
    logic          busy;

    int errs = 0;
    int checks = 0;
    int cyc = 0;
    int rdy_mode = 0;   // 0: always ready, 1: random, 2: test drives it

    beat_t q0[$], q1[$], m0[$], m1[$], exp_q[$], obs[$];

    net_tx_pkt_arbiter #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .CNT_WIDTH(CW)) dut (
        .net_clk(clk), .net_aresetn(arstn),
        .s_axis_in0_data(d0), .s_axis_in0_keep(k0), .s_axis_in0_last(l0),
        .s_axis_in0_valid(v0), .s_axis_in0_ready(rdy0),
        .s_axis_in1_data(d1), .s_axis_in1_keep(k1), .s_axis_in1_last(l1),
        .s_axis_in1_valid(v1), .s_axis_in1_ready(rdy1),
        .m_axis_net_tx_data(o_data), .m_axis_net_tx_keep(o_keep), .m_axis_net_tx_last(o_last),
        .m_axis_net_tx_dest(o_dest), .m_axis_net_tx_valid(o_valid), .m_axis_net_tx_ready(m_ready),
        .pkt_cnt0(cnt0), .pkt_cnt1(cnt1), .busy(busy)
    );

    initial forever #5 clk = ~clk;
    initial forever begin @(posedge clk); cyc = cyc + 1; end

    initial forever begin
        @(posedge clk); #1;
        if (rdy_mode == 0) m_ready = 1'b1;
        else if (rdy_mode == 1) m_ready = ($urandom_range(0, 3) != 0);
    end

    // Output monitor: records accepted beats and checks hold-stable during stalls.
    initial begin
        beat_t b, pb;
        bit    stalled;
        stalled = 0;
        forever begin
            @(negedge clk);
            if (stalled && arstn) begin
                checks++;
                if (o_valid !== 1'b1 || o_data !== pb.data || o_keep !== pb.keep ||
                    o_last !== pb.last || o_dest !== pb.dest) begin
                    errs++;
                    $display("FAIL stall_hold: valid=%b data=%h required data=%h", o_valid, o_data[63:0], pb.data[63:0]);
                end
            end
            b.data = o_data; b.keep = o_keep; b.last = o_last; b.dest = o_dest; b.cyc = cyc;
            if (arstn && o_valid && m_ready) obs.push_back(b);
            stalled = arstn && o_valid && !m_ready;
            pb = b;
        end
    end

    task automatic do_reset();
        arstn = 1'b0; v0 = 0; v1 = 0;
        @(posedge clk); #1;
        arstn = 1'b1;
        q0.delete(); q1.delete(); m0.delete(); m1.delete(); exp_q.delete(); obs.delete();
    endtask

    task automatic gen_pkt(input int s, input int len, input int base, input bit rnd);
        beat_t b;
        for (int i = 0; i < len; i++) begin
            if (rnd) begin
                for (int w = 0; w < DW / 32; w++) b.data[w*32 +: 32] = $urandom();
                b.keep = ($urandom_range(0, 7) == 0) ? '0 : {$urandom(), $urandom()};
            end else begin
                b.data = DW'(base + i);
                b.keep = '1;
            end
            b.last = (i == len - 1);
            b.dest = s[0];
            b.cyc  = 0;
            if (s == 0) begin q0.push_back(b); m0.push_back(b); end
            else        begin q1.push_back(b); m1.push_back(b); end
        end
    endtask

    // Reference: whole packets alternate between sources that have one waiting, starting with 'first'.
    task automatic model(input bit first);
        bit    t;
        beat_t b;
        t = first;
        while (m0.size() > 0 || m1.size() > 0) begin
            if (!t && m0.size() == 0) t = 1;
            else if (t && m1.size() == 0) t = 0;
            do begin
                b = t ? m1.pop_front() : m0.pop_front();
                b.dest = t;
                exp_q.push_back(b);
            end while (!b.last);
            t = !t;
        end
    endtask

    task automatic drive_src(input int s);
        beat_t b;
        int    n;
        while ((s == 0) ? (q0.size() > 0) : (q1.size() > 0)) begin
            if (s == 0) begin b = q0.pop_front(); d0 = b.data; k0 = b.keep; l0 = b.last; v0 = 1; end
            else        begin b = q1.pop_front(); d1 = b.data; k1 = b.keep; l1 = b.last; v1 = 1; end
            n = 0;
            @(negedge clk);
            while (!((s == 0) ? rdy0 : rdy1) && n < 3000) begin @(negedge clk); n++; end
            if (n >= 3000) begin
                checks++; errs++;
                $display("FAIL src%0d_accept_timeout: ready never seen, required ready=1", s);
                if (s == 0) v0 = 0; else v1 = 0;
                return;
            end
            @(posedge clk); #1;
        end
        if (s == 0) v0 = 0; else v1 = 0;
    endtask

    task automatic wait_out(input int n, input string name);
        int k = 0;
        while (obs.size() < n && k < 3000) begin @(negedge clk); k++; end
        repeat (3) @(negedge clk);
        checks++;
        if (obs.size() != n) begin
            errs++;
            $display("FAIL %s_beat_count: got %0d beats, required %0d", name, obs.size(), n);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        arstn = 0; v0 = 1; v1 = 1; l0 = 1; l1 = 1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if ({o_valid, o_last, o_dest, rdy0, rdy1, busy} !== 6'b0) begin
            errs++;
            $display("FAIL reset_ctrl: valid/last/dest/rdy0/rdy1/busy=%b required 000000",
                     {o_valid, o_last, o_dest, rdy0, rdy1, busy});
        end
        checks++;
        if (o_data !== '0 || o_keep !== '0) begin
            errs++;
            $display("FAIL reset_data: data=%h keep=%h required 0", o_data[63:0], o_keep);
        end
        checks++;
        if (cnt0 !== 4'd0 || cnt1 !== 4'd0) begin
            errs++;
            $display("FAIL reset_cnt: cnt0=%0d cnt1=%0d required 0 0", cnt0, cnt1);
        end
        v0 = 0; v1 = 0; l0 = 0; l1 = 0;
        @(posedge clk); #1;
        arstn = 1;
    endtask

    task automatic test_single();
        int s;
        do_reset();
        rdy_mode = 0;
        gen_pkt(0, 3, 'hA1, 0);
        model(1'b0);
        s = cyc;
        drive_src(0);
        wait_out(3, "single");
        for (int i = 0; i < 3 && i < obs.size(); i++) begin
            checks++;
            if (obs[i].data !== exp_q[i].data || obs[i].last !== exp_q[i].last ||
                obs[i].dest !== 1'b0 || obs[i].cyc != s + 2 + i) begin
                errs++;
                $display("FAIL single_beat%0d: data=%h last=%b dest=%b cyc=%0d required data=%h last=%b dest=0 cyc=%0d",
                         i, obs[i].data[31:0], obs[i].last, obs[i].dest, obs[i].cyc - s,
                         exp_q[i].data[31:0], exp_q[i].last, 2 + i);
            end
        end
        checks++;
        if (cnt0 !== 4'd1 || cnt1 !== 4'd0) begin
            errs++;
            $display("FAIL single_cnt: cnt0=%0d cnt1=%0d required 1 0", cnt0, cnt1);
        end
    endtask

    task automatic test_tie();
        do_reset();
        rdy_mode = 0;
        gen_pkt(0, 2, 'h100, 0);
        gen_pkt(1, 2, 'h200, 0);
        model(1'b0);
        fork drive_src(0); drive_src(1); join
        wait_out(4, "tie");
        for (int i = 0; i < 4 && i < obs.size(); i++) begin
            checks++;
            if (obs[i].data !== exp_q[i].data || obs[i].dest !== exp_q[i].dest || obs[i].last !== exp_q[i].last) begin
                errs++;
                $display("FAIL tie_beat%0d: data=%h dest=%b last=%b required data=%h dest=%b last=%b", i,
                         obs[i].data[31:0], obs[i].dest, obs[i].last, exp_q[i].data[31:0], exp_q[i].dest, exp_q[i].last);
            end
        end
        if (obs.size() >= 4) begin
            checks++;
            if (obs[2].cyc - obs[1].cyc != 2) begin
                errs++;
                $display("FAIL tie_gap: spacing=%0d cycles required 2", obs[2].cyc - obs[1].cyc);
            end
        end
        checks++;
        if (cnt0 !== 4'd1 || cnt1 !== 4'd1) begin
            errs++;
            $display("FAIL tie_cnt: cnt0=%0d cnt1=%0d required 1 1", cnt0, cnt1);
        end
    endtask

    task automatic test_fairness();
        logic [4:0] dseq;
        do_reset();
        rdy_mode = 0;
        for (int p = 0; p < 4; p++) gen_pkt(0, 1, 'h300 + p, 0);
        gen_pkt(1, 1, 'h400, 0);
        model(1'b0);
        fork drive_src(0); drive_src(1); join
        wait_out(5, "fair");
        dseq = '0;
        for (int i = 0; i < 5 && i < obs.size(); i++) dseq[4 - i] = obs[i].dest;
        checks++;
        if (dseq !== 5'b01000) begin
            errs++;
            $display("FAIL fair_order: dest sequence=%b required 01000", dseq);
        end
        for (int i = 0; i < 5 && i < obs.size(); i++) begin
            checks++;
            if (obs[i].data !== exp_q[i].data) begin
                errs++;
                $display("FAIL fair_data%0d: data=%h required %h", i, obs[i].data[31:0], exp_q[i].data[31:0]);
            end
        end
    endtask

    task automatic test_backpressure();
        int s;
        do_reset();
        rdy_mode = 2;
        m_ready = 1;
        gen_pkt(1, 4, 'h500, 1);
        model(1'b0);
        s = cyc;
        fork
            drive_src(1);
            begin
                repeat (3) @(posedge clk);
                #1 m_ready = 0;
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    checks++;
                    if (o_valid !== 1'b1 || o_data !== exp_q[1].data || rdy1 !== 1'b0) begin
                        errs++;
                        $display("FAIL bp_stall%0d: valid=%b data=%h rdy1=%b required valid=1 data=%h rdy1=0",
                                 k, o_valid, o_data[63:0], rdy1, exp_q[1].data[63:0]);
                    end
                    @(posedge clk); #1;
                end
                m_ready = 1;
            end
        join
        wait_out(4, "bp");
        for (int i = 0; i < 4 && i < obs.size(); i++) begin
            checks++;
            if (obs[i].data !== exp_q[i].data || obs[i].keep !== exp_q[i].keep ||
                obs[i].last !== exp_q[i].last || obs[i].dest !== 1'b1) begin
                errs++;
                $display("FAIL bp_beat%0d: data=%h last=%b dest=%b required data=%h last=%b dest=1",
                         i, obs[i].data[63:0], obs[i].last, obs[i].dest, exp_q[i].data[63:0], exp_q[i].last);
            end
        end
        rdy_mode = 0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        rdy_mode = 0;
        v0 = 1; l0 = 0; k0 = '1; d0 = DW'('h51);
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (rdy0 !== 1'b1 || busy !== 1'b1) begin
            errs++;
            $display("FAIL mid_grant_latency: rdy0=%b busy=%b required 1 1", rdy0, busy);
        end
        @(posedge clk); #1 d0 = DW'('h52);
        @(posedge clk); #1 d0 = DW'('h53);
        arstn = 0;
        @(negedge clk);
        checks++;
        if (o_valid !== 1'b1 || o_data !== DW'('h52)) begin
            errs++;
            $display("FAIL mid_beat2: valid=%b data=%h required valid=1 data=52", o_valid, o_data[31:0]);
        end
        @(posedge clk); #1 v0 = 0;
        @(negedge clk);
        checks++;
        if (o_valid !== 1'b0 || busy !== 1'b0 || cnt0 !== 4'd0 || cnt1 !== 4'd0 || o_data !== '0) begin
            errs++;
            $display("FAIL mid_reset: valid=%b busy=%b cnt0=%0d cnt1=%0d required 0 0 0 0",
                     o_valid, busy, cnt0, cnt1);
        end
        @(posedge clk); #1 arstn = 1;
        obs.delete();
        gen_pkt(1, 1, 'h77, 0);
        drive_src(1);
        wait_out(1, "mid_fresh");
        checks++;
        if (obs.size() < 1 || obs[0].dest !== 1'b1 || obs[0].data !== DW'('h77) || obs[0].last !== 1'b1) begin
            errs++;
            $display("FAIL mid_fresh: beats=%0d required one beat dest=1 data=77 last=1", obs.size());
        end
        checks++;
        if (cnt1 !== 4'd1 || cnt0 !== 4'd0) begin
            errs++;
            $display("FAIL mid_fresh_cnt: cnt0=%0d cnt1=%0d required 0 1", cnt0, cnt1);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        rdy_mode = 1;
        for (int p = 0; p < 17; p++) gen_pkt(1, $urandom_range(1, 2), 0, 1);
        model(1'b0);
        drive_src(1);
        wait_out(exp_q.size(), "wrap");
        for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
            checks++;
            if (obs[i].data !== exp_q[i].data || obs[i].last !== exp_q[i].last || obs[i].dest !== 1'b1) begin
                errs++;
                $display("FAIL wrap_beat%0d: data=%h last=%b dest=%b required data=%h last=%b dest=1",
                         i, obs[i].data[63:0], obs[i].last, obs[i].dest, exp_q[i].data[63:0], exp_q[i].last);
            end
        end
        checks++;
        if (cnt1 !== 4'd1 || cnt0 !== 4'd0) begin
            errs++;
            $display("FAIL wrap_cnt: cnt0=%0d cnt1=%0d required 0 1", cnt0, cnt1);
        end
        rdy_mode = 0;
    endtask

    task automatic test_random();
        int n0, n1;
        for (int r = 0; r < 4; r++) begin
            do_reset();
            rdy_mode = 1;
            n0 = $urandom_range(2, 9);
            n1 = $urandom_range(2, 9);
            for (int p = 0; p < n0; p++) gen_pkt(0, $urandom_range(1, 4), 0, 1);
            for (int p = 0; p < n1; p++) gen_pkt(1, $urandom_range(1, 4), 0, 1);
            model(1'b0);
            fork drive_src(0); drive_src(1); join
            wait_out(exp_q.size(), "rand");
            for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
                checks++;
                if (obs[i].data !== exp_q[i].data || obs[i].keep !== exp_q[i].keep ||
                    obs[i].last !== exp_q[i].last || obs[i].dest !== exp_q[i].dest) begin
                    errs++;
                    $display("FAIL rand%0d_beat%0d: data=%h keep=%h last=%b dest=%b required data=%h keep=%h last=%b dest=%b",
                             r, i, obs[i].data[63:0], obs[i].keep, obs[i].last, obs[i].dest,
                             exp_q[i].data[63:0], exp_q[i].keep, exp_q[i].last, exp_q[i].dest);
                end
            end
            checks++;
            if (cnt0 !== 4'(n0 % 16) || cnt1 !== 4'(n1 % 16)) begin
                errs++;
                $display("FAIL rand%0d_cnt: cnt0=%0d cnt1=%0d required %0d %0d", r, cnt0, cnt1, n0 % 16, n1 % 16);
            end
        end
        rdy_mode = 0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_tie();
        test_fairness();
        test_backpressure();
        test_reset_mid();
        test_wrap();
        test_random();
        repeat (5) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
